// File: rtl/nubus_slave.sv
// rtl/nubus_slave.sv - NuBus slave: decodes START cycles to this slot, runs a local
// req/ready handshake, and terminates with a one-clock ACK carrying status.
module nubus_slave #(
    parameter bit SUPER_EN = 1'b0,
    parameter int WDT_W    = 8
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic [3:0]  nub_idn,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm0n,
    input  logic        nub_tm1n,
    input  logic [31:0] nub_adn,
    output logic [31:0] slv_adn_o,
    output logic        slv_ad_oe_o,
    output logic        slv_ackn_o,
    output logic        slv_tm0n_o,
    output logic        slv_tm1n_o,
    output logic        slv_ctl_oe_o,
    output logic        slv_busy_o,
    output logic [29:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_req_o,
    input  logic        mem_ready_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state;
    logic               unsup;
    logic [WDT_W-1:0]   wdt;

    logic [3:0]  id;
    logic [31:0] ad;
    logic        start, ack, tm0, tm1;
    logic        match, addr_cycle;
    logic [3:0]  be_dec;
    logic        unsup_dec;

    assign id    = ~nub_idn;
    assign ad    = ~nub_adn;
    assign start = ~nub_startn;
    assign ack   = ~nub_ackn;
    assign tm0   = ~nub_tm0n;
    assign tm1   = ~nub_tm1n;

    assign match = (ad[31:24] == {4'hF, id}) || (SUPER_EN && (ad[31:28] == id));
    // start & ack is an attention cycle (lock/null); never a transfer to us
    assign addr_cycle = start && !ack && match;

    always_comb begin
        be_dec    = 4'b0000;
        unsup_dec = 1'b0;
        if (!tm0) begin
            be_dec = 4'b0001 << ad[1:0];
        end else begin
            case (ad[1:0])
                2'b00:   be_dec = 4'b1111;
                2'b10:   be_dec = 4'b0011;
                2'b11:   be_dec = 4'b1100;
                default: unsup_dec = 1'b1;
            endcase
        end
    end

    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            state        <= S_IDLE;
            unsup        <= 1'b0;
            wdt          <= '0;
            slv_adn_o    <= '1;
            slv_ad_oe_o  <= 1'b0;
            slv_ackn_o   <= 1'b1;
            slv_tm0n_o   <= 1'b1;
            slv_tm1n_o   <= 1'b1;
            slv_ctl_oe_o <= 1'b0;
            slv_busy_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            mem_req_o    <= 1'b0;
        end else begin
            wdt <= '0;
            case (state)
                S_IDLE: begin
                    if (addr_cycle) begin
                        state      <= S_DATA;
                        slv_busy_o <= 1'b1;
                        mem_addr_o <= ad[31:2];
                        mem_we_o   <= !tm1;
                        mem_be_o   <= be_dec;
                        unsup      <= unsup_dec;
                    end
                end
                S_DATA: begin
                    if (mem_we_o) begin
                        mem_wdata_o <= ad;
                    end
                    if (unsup) begin
                        state        <= S_ACK;
                        slv_ctl_oe_o <= 1'b1;
                        slv_ackn_o   <= 1'b0;
                        slv_tm0n_o   <= 1'b0;
                        slv_tm1n_o   <= 1'b1;
                        slv_ad_oe_o  <= !mem_we_o;
                        slv_adn_o    <= '1;
                    end else begin
                        state     <= S_WAIT;
                        mem_req_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    wdt <= wdt + WDT_W'(1);
                    if (mem_ready_i) begin
                        state        <= S_ACK;
                        mem_req_o    <= 1'b0;
                        slv_ctl_oe_o <= 1'b1;
                        slv_ackn_o   <= 1'b0;
                        slv_tm0n_o   <= !mem_err_i;
                        slv_tm1n_o   <= 1'b1;
                        slv_ad_oe_o  <= !mem_we_o;
                        slv_adn_o    <= mem_err_i ? 32'hFFFF_FFFF : ~mem_rdata_i;
                    end else if (&wdt) begin
                        // watchdog expired on the 2^WDT_W-th WAIT edge
                        state        <= S_ACK;
                        mem_req_o    <= 1'b0;
                        slv_ctl_oe_o <= 1'b1;
                        slv_ackn_o   <= 1'b0;
                        slv_tm0n_o   <= 1'b1;
                        slv_tm1n_o   <= 1'b0;
                        slv_ad_oe_o  <= !mem_we_o;
                        slv_adn_o    <= '1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    slv_busy_o   <= 1'b0;
                    slv_ctl_oe_o <= 1'b0;
                    slv_ad_oe_o  <= 1'b0;
                    slv_ackn_o   <= 1'b1;
                    slv_tm0n_o   <= 1'b1;
                    slv_tm1n_o   <= 1'b1;
                    slv_adn_o    <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_slave.sv
// tb/tb_nubus_slave.sv - scoreboard bench for nubus_slave.
module tb_nubus_slave;

    localparam int WDT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  nub_idn;
    logic        nub_startn, nub_ackn, nub_tm0n, nub_tm1n;
    logic [31:0] nub_adn;
    logic [31:0] slv_adn_o;
    logic        slv_ad_oe_o, slv_ackn_o, slv_tm0n_o, slv_tm1n_o, slv_ctl_oe_o, slv_busy_o;
    logic [29:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_req_o;
    logic        mem_ready_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    nubus_slave #(.SUPER_EN(1'b0), .WDT_W(WDT)) dut (
        .nub_clkn(clk), .nub_reset(rst), .nub_idn(nub_idn),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm0n(nub_tm0n), .nub_tm1n(nub_tm1n),
        .nub_adn(nub_adn), .slv_adn_o(slv_adn_o), .slv_ad_oe_o(slv_ad_oe_o),
        .slv_ackn_o(slv_ackn_o), .slv_tm0n_o(slv_tm0n_o), .slv_tm1n_o(slv_tm1n_o),
        .slv_ctl_oe_o(slv_ctl_oe_o), .slv_busy_o(slv_busy_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_req_o(mem_req_o), .mem_ready_i(mem_ready_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  status;
        bit          rd;
        logic [31:0] adn;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit   ack_now;
        exp_t e;
        ack_now = slv_ctl_oe_o && !slv_ackn_o;
        if (ack_now) begin
            check("ack_one_clk", 32'(prev_ack), 0);
            check("ack_req_low", 32'(mem_req_o), 0);
            check("ack_busy", 32'(slv_busy_o), 1);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack_now), 0);
            end else begin
                e = sb.pop_front();
                check("ack_cyc", cyc, e.cyc);
                check("ack_status", {30'd0, ~slv_tm1n_o, ~slv_tm0n_o}, {30'd0, e.status});
                check("ad_oe", 32'(slv_ad_oe_o), 32'(e.rd));
                if (e.rd) check("rdata_drive", slv_adn_o, e.adn);
            end
        end else if (prev_ack) begin
            check("oe_drop", {30'd0, slv_ctl_oe_o, slv_ad_oe_o}, 0);
        end
        prev_ack = ack_now;
    end

    task automatic idle_bus();
        nub_startn = 1'b1;
        nub_ackn   = 1'b1;
        nub_tm0n   = 1'b1;
        nub_tm1n   = 1'b1;
        nub_adn    = '1;
    endtask

    // d = idle cycles before ready after E1; d < 0 means ready is never given
    task automatic do_txn(input logic [31:0] addr, input bit rd, input bit tm0,
                          input logic [31:0] wd, input int d,
                          input logic [31:0] rdata, input bit err);
        exp_t       e;
        bit         unsup, saw_req, done;
        logic [3:0] be;
        int         e0;
        unsup = tm0 && (addr[1:0] == 2'b01);
        if (!tm0) be = 4'b0001 << addr[1:0];
        else if (addr[1:0] == 2'b00) be = 4'b1111;
        else if (addr[1:0] == 2'b10) be = 4'b0011;
        else if (addr[1:0] == 2'b11) be = 4'b1100;
        else be = 4'b0000;
        if (unsup || (err && d >= 0)) e.status = 2'b01;
        else if (d < 0) e.status = 2'b10;
        else e.status = 2'b00;
        e.rd  = rd;
        e.adn = (e.status == 2'b00) ? ~rdata : 32'hFFFF_FFFF;
        @(negedge clk);
        e0 = cyc + 1;
        if (unsup) e.cyc = e0 + 1;
        else if (d < 0) e.cyc = e0 + 1 + (1 << WDT);
        else e.cyc = e0 + 2 + d;
        sb.push_back(e);
        nub_startn = 1'b0;
        nub_tm1n   = ~rd;
        nub_tm0n   = ~tm0;
        nub_adn    = ~addr;
        @(negedge clk);
        idle_bus();
        if (!rd) nub_adn = ~wd;
        saw_req = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            nub_adn     = '1;
            mem_ready_i = 1'b0;
            mem_err_i   = 1'b0;
            if (mem_req_o) saw_req = 1'b1;
            if (d >= 0 && !unsup && cyc == e0 + 1 + d) begin
                check("req_held", 32'(mem_req_o), 1);
                check("mem_addr", {2'b00, mem_addr_o}, {2'b00, addr[31:2]});
                check("mem_be", {28'd0, mem_be_o}, {28'd0, be});
                check("mem_we", 32'(mem_we_o), 32'(!rd));
                if (!rd) check("mem_wdata", mem_wdata_o, wd);
                mem_ready_i = 1'b1;
                mem_err_i   = err;
                mem_rdata_i = rdata;
            end
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check("txn_done", 32'(done), 1);
            sb.delete();
        end
        check("req_seen", 32'(saw_req), 32'(!unsup));
    endtask

    initial begin
        int e0;
        nub_idn     = ~4'd9;
        mem_ready_i = 1'b0;
        mem_err_i   = 1'b0;
        mem_rdata_i = '0;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ackn", 32'(slv_ackn_o), 1);
        check("rst_tmn", {30'd0, slv_tm1n_o, slv_tm0n_o}, 3);
        check("rst_adn", slv_adn_o, 32'hFFFF_FFFF);
        check("rst_oe", {30'd0, slv_ctl_oe_o, slv_ad_oe_o}, 0);
        check("rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o[25:0]}, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_busy", 32'(slv_busy_o), 0);
        rst = 1'b0;

        do_txn(32'hF900_1230, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        do_txn(32'hF900_0002, 1'b1, 1'b0, 32'h0, 3, 32'h00AB_0000, 1'b0);

        // foreign slot, then attention cycle to our slot: both ignored
        @(negedge clk);
        nub_startn = 1'b0; nub_tm1n = 1'b0; nub_adn = ~32'hF800_0000;
        @(negedge clk);
        nub_ackn = 1'b0; nub_adn = ~32'hF900_0000;
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        check("ignored_start", {28'd0, slv_busy_o, mem_req_o, slv_ctl_oe_o, slv_ad_oe_o}, 0);

        do_txn(32'hF900_0001, 1'b0, 1'b1, 32'h1234_5678, 0, 32'h0, 1'b0);
        do_txn(32'hF900_0010, 1'b1, 1'b1, 32'h0, -1, 32'h0, 1'b0);
        do_txn(32'hF900_0022, 1'b0, 1'b1, 32'hCAFE_0001, 1, 32'h0, 1'b0);
        do_txn(32'hF900_0043, 1'b0, 1'b1, 32'h5555_AAAA, 2, 32'h0, 1'b0);
        do_txn(32'hF900_0080, 1'b1, 1'b1, 32'h0, 0, 32'h1111_2222, 1'b1);
        do_txn(32'hF9FF_FFFC, 1'b1, 1'b1, 32'h0, 0, 32'h8765_4321, 1'b0);

        // reset during WAIT aborts the cycle without ACK
        @(negedge clk);
        e0 = cyc + 1;
        nub_startn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0; nub_adn = ~32'hF900_0004;
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        check("wait_req", 32'(mem_req_o), 1);
        check("wait_cyc", cyc, e0 + 3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_req", 32'(mem_req_o), 0);
        check("abort_idle", {29'd0, slv_busy_o, slv_ctl_oe_o, slv_ad_oe_o}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_txn(32'hF900_0100, 1'b0, 1'b1, 32'h0BAD_F00D, 1, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
